// File: rtl/id_pipe_decode_if.sv
// Fetch-to-decode handshake and decoded-field bundle for id_pipe_decode.
// slave is the decode stage's view; master is the fetch/consumer side.
interface id_pipe_decode_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      op;
    logic [5:0]      func;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [XLEN-1:0] imm_ext;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] pc_out;
    logic            is_rtype;
    logic            is_branch;
    logic            is_jump;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, op, func, rs, rt, rd, shamt,
        output imm_ext, jump_target, pc_out,
        output is_rtype, is_branch, is_jump
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, op, func, rs, rt, rd, shamt,
        input  imm_ext, jump_target, pc_out,
        input  is_rtype, is_branch, is_jump
    );
endinterface

// File: rtl/id_pipe_decode.sv
// MIPS instruction decode stage: combinational field split and classify,
// stored in a 2-entry skid buffer with valid/ready flow control and flush.
module id_pipe_decode #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    id_pipe_decode_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [5:0]      op;
        logic [5:0]      func;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [XLEN-1:0] imm_ext;
        logic [PC_W-1:0] jump_target;
        logic [PC_W-1:0] pc;
        logic            is_rtype;
        logic            is_branch;
        logic            is_jump;
    } dec_t;

    state_t          state;
    logic            in_ready_q;
    logic            out_valid_q;
    dec_t            head;
    dec_t            tail;
    dec_t            dec;
    logic [PC_W-1:0] pc4;
    logic [PC_W-1:0] jt;
    logic [15:0]     imm;
    logic [5:0]      opc;
    logic [5:0]      fn;
    logic            is_logic;
    logic            is_lui;
    logic            push;
    logic            pop;

    assign imm      = bus.in_instr[15:0];
    assign opc      = bus.in_instr[31:26];
    assign fn       = bus.in_instr[5:0];
    assign is_logic = (opc == 6'h0c) || (opc == 6'h0d) || (opc == 6'h0e);
    assign is_lui   = (opc == 6'h0f);
    assign pc4      = bus.in_pc + PC_W'(4);

    always_comb begin
        jt       = pc4;
        jt[27:0] = {bus.in_instr[25:0], 2'b00};
    end

    always_comb begin
        dec             = '0;
        dec.op          = opc;
        dec.func        = fn;
        dec.rs          = bus.in_instr[25:21];
        dec.rt          = bus.in_instr[20:16];
        dec.rd          = bus.in_instr[15:11];
        dec.shamt       = bus.in_instr[10:6];
        dec.jump_target = jt;
        dec.pc          = bus.in_pc;
        dec.is_rtype    = (opc == 6'h00);
        dec.is_branch   = (opc == 6'h01) || (opc[5:2] == 4'b0001);
        dec.is_jump     = (opc == 6'h02) || (opc == 6'h03) ||
                          ((opc == 6'h00) &&
                           ((fn == 6'h08) || (fn == 6'h09)));
        unique case (1'b1)
            is_logic: dec.imm_ext = {{(XLEN-16){1'b0}}, imm};
            // LUI: sign of imm16 lands in bit 31 and extends upward
            is_lui:   dec.imm_ext = {{(XLEN-16){imm[15]}}, imm} << 16;
            default:  dec.imm_ext = {{(XLEN-16){imm[15]}}, imm};
        endcase
    end

    assign push = bus.in_valid && in_ready_q;
    assign pop  = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head        <= '0;
            tail        <= '0;
        end else if (bus.flush) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: if (push) begin
                    head        <= dec;
                    state       <= ONE;
                    out_valid_q <= 1'b1;
                end
                ONE: begin
                    if (push && !pop) begin
                        tail       <= dec;
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (push && pop) begin
                        head <= dec;
                    end else if (pop) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: if (pop) begin
                    head       <= tail;
                    state      <= ONE;
                    in_ready_q <= 1'b1;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.op          = head.op;
    assign bus.func        = head.func;
    assign bus.rs          = head.rs;
    assign bus.rt          = head.rt;
    assign bus.rd          = head.rd;
    assign bus.shamt       = head.shamt;
    assign bus.imm_ext     = head.imm_ext;
    assign bus.jump_target = head.jump_target;
    assign bus.pc_out      = head.pc;
    assign bus.is_rtype    = head.is_rtype;
    assign bus.is_branch   = head.is_branch;
    assign bus.is_jump     = head.is_jump;
endmodule
